// File: rtl/hamming_pkg.sv
// hamming_pkg
// Shared Hamming code helpers: check-bit count, codeword width, the
// power-of-two test and the codeword-position to data-bit mapping. The
// decoder imports the same functions so both ends agree on the layout.
// Also holds the skid buffer state encoding.
package hamming_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } skid_state_t;

    // Smallest P with 2^P >= data_w + P + 1. The downward scan keeps the smallest hit.
    function automatic int hamming_p(input int data_w);
        int p;
        p = 9;
        for (int i = 8; i >= 1; i--) begin
            if ((32'sd1 <<< i) >= (data_w + i + 32'sd1)) begin
                p = i;
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    function automatic logic is_pow2(input int x);
        return (x > 32'sd0) && ((x & (x - 32'sd1)) == 32'sd0);
    endfunction

    function automatic int cw_width(input int data_w, input int secded);
        return data_w + hamming_p(data_w) + secded;
    endfunction

    // Data index stored at 1-based codeword position pos. Parity positions
    // return 0; callers must only use the result for non-power-of-two positions.
    function automatic int data_index(input int pos);
        int n_par;
        n_par = 0;
        for (int j = 0; j < 9; j++) begin
            if ((32'sd1 <<< j) <= pos) begin
                n_par = n_par + 32'sd1;
            end else begin
                n_par = n_par;
            end
        end
        if (is_pow2(pos) || (pos < 32'sd3)) begin
            return 0;
        end else begin
            return pos - 32'sd1 - n_par;
        end
    endfunction

endpackage

// File: rtl/hamming_secded_enc_if.sv
// hamming_secded_enc_if
// Stream bundle for the encoder: input word handshake with fault-injection
// controls, and the codeword output handshake.
//   slave  : the encoder view (consumes in_*, produces out_*)
//   master : the producer/consumer view
interface hamming_secded_enc_if
    import hamming_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SECDED = 1
);
    localparam int CW_W  = cw_width(DATA_W, SECDED);
    localparam int POS_W = $clog2(CW_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              inj_en;
    logic [POS_W-1:0]  inj_pos;
    logic              out_valid;
    logic              out_ready;
    logic [CW_W-1:0]   out_code;
    logic              out_injected;

    modport slave (
        input  in_valid, in_data, inj_en, inj_pos, out_ready,
        output in_ready, out_valid, out_code, out_injected
    );

    modport master (
        output in_valid, in_data, inj_en, inj_pos, out_ready,
        input  in_ready, out_valid, out_code, out_injected
    );

endinterface

// File: rtl/hamming_skid.sv
// hamming_skid
// Two-entry valid/ready skid buffer: a main output register plus one skid
// register. in_ready is registered and means "skid empty", so the upstream
// path never sees a combinational dependency on out_ready.
// Ports: clk, rst (sync, active high), in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data. Payload registers are not reset.
module hamming_skid
    import hamming_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    skid_state_t  state_r;
    skid_state_t  state_nxt_s;
    logic         in_ready_r;
    logic         out_valid_r;
    logic [W-1:0] main_r;
    logic [W-1:0] skid_r;
    logic         in_xfer_s;
    logic         out_xfer_s;
    logic         load_main_in_s;
    logic         load_main_skid_s;
    logic         load_skid_s;

    assign in_xfer_s  = in_valid & in_ready_r;
    assign out_xfer_s = out_valid_r & out_ready;
    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_data   = main_r;

    // Next-state and register-load decode.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    state_nxt_s    = ST_ONE;
                    load_main_in_s = 1'b1;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    state_nxt_s    = ST_ONE;
                    load_main_in_s = 1'b1;
                end else if (in_xfer_s) begin
                    // Consumer stalled: park the new word behind main.
                    state_nxt_s = ST_FULL;
                    load_skid_s = 1'b1;
                end else if (out_xfer_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (out_xfer_s) begin
                    state_nxt_s      = ST_ONE;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State, ready and valid registers; reset discards both entries at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_FULL);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    // Payload registers; they only move on a load so a stalled word holds.
    always_ff @(posedge clk) begin
        if (load_main_in_s) begin
            main_r <= in_data;
        end else if (load_main_skid_s) begin
            main_r <= skid_r;
        end
        if (load_skid_s) begin
            skid_r <= in_data;
        end
    end

endmodule

// File: rtl/hamming_secded_enc.sv
// hamming_secded_enc
// Pipelined Hamming SEC / SECDED encoder. Codeword position k (1-based)
// is out_code[k-1]; check bit j sits at position 2^j; data bits fill the
// other positions upward from position 3. With SECDED=1 the MSB carries
// overall parity of the lower bits. An optional single-bit flip is applied
// after all parity is formed. The result goes through a two-entry skid.
// Ports: clk, rst (sync, active high), bus (slave view of the stream
//        bundle), enc_count (accepted words, saturating at 16'hFFFF).
module hamming_secded_enc
    import hamming_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SECDED = 1,
    parameter int INJ_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    hamming_secded_enc_if.slave  bus,
    output logic [15:0]          enc_count
);
    localparam int P     = hamming_p(DATA_W);
    localparam int N     = DATA_W + P;
    localparam int CW_W  = cw_width(DATA_W, SECDED);
    localparam int POS_W = $clog2(CW_W);
    localparam logic [POS_W:0] POS_LIMIT = (POS_W + 1)'(CW_W);

    logic [N-1:0]    spread_s;
    logic [P-1:0]    par_s;
    logic [N-1:0]    body_s;
    logic [CW_W-1:0] code_s;
    logic [CW_W-1:0] mask_s;
    logic            flip_s;
    logic            in_xfer_s;
    logic            in_ready_s;
    logic            out_valid_s;
    logic [CW_W:0]   payload_s;

    assign in_xfer_s = bus.in_valid & in_ready_s;

    // Scatter data bits into their codeword positions; parity slots stay zero.
    always_comb begin
        spread_s = '0;
        for (int k = 1; k <= N; k++) begin
            if (!is_pow2(k)) begin
                spread_s[k-1] = bus.in_data[data_index(k)];
            end else begin
                spread_s[k-1] = 1'b0;
            end
        end
    end

    // Check bit j: even parity over every position whose index has bit j set.
    always_comb begin
        par_s = '0;
        for (int j = 0; j < P; j++) begin
            for (int k = 1; k <= N; k++) begin
                if (((k >> j) & 1) == 1) begin
                    par_s[j] = par_s[j] ^ spread_s[k-1];
                end else begin
                    par_s[j] = par_s[j];
                end
            end
        end
    end

    // Drop check bits into the power-of-two slots.
    always_comb begin
        body_s = spread_s;
        for (int j = 0; j < P; j++) begin
            body_s[(1 << j) - 1] = par_s[j];
        end
    end

    if (SECDED != 0) begin : g_secded
        assign code_s = {^body_s, body_s};
    end else begin : g_sec
        assign code_s = body_s;
    end

    if (INJ_EN != 0) begin : g_inj
        // Out-of-range indices are a deliberate "no flip" request.
        assign flip_s = bus.inj_en & in_xfer_s & ({1'b0, bus.inj_pos} < POS_LIMIT);
        assign mask_s = flip_s ? ({{(CW_W-1){1'b0}}, 1'b1} << bus.inj_pos) : {CW_W{1'b0}};
    end else begin : g_no_inj
        assign flip_s = 1'b0;
        assign mask_s = {CW_W{1'b0}};
    end

    hamming_skid #(
        .W (CW_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (in_ready_s),
        .in_data   ({flip_s, code_s ^ mask_s}),
        .out_valid (out_valid_s),
        .out_ready (bus.out_ready),
        .out_data  (payload_s)
    );

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_s;
    assign bus.out_code     = payload_s[CW_W-1:0];
    assign bus.out_injected = payload_s[CW_W];

    // Accepted-word counter, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_count <= 16'h0000;
        end else if (in_xfer_s && (enc_count != 16'hFFFF)) begin
            enc_count <= enc_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_hamming_secded_enc.sv
// tb_hamming_secded_enc
// Four encoders (DATA_W 8/SEC, 32, 64, 120 SECDED) share one stimulus
// stream and move in lockstep. Accepted words go into a scoreboard queue;
// each output transfer is checked against an independent syndrome-based
// model for every width, and injected words must decode to the flipped
// position. Directed steps cover reset, known vectors, injection,
// backpressure and mid-stream reset.
module tb_hamming_secded_enc;

    localparam int DWS  [4] = '{8, 32, 64, 120};
    localparam int SECS [4] = '{0, 1, 1, 1};

    typedef struct {
        logic [255:0] data;
        logic         inj;
        logic [7:0]   pos;
    } sb_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [255:0] in_data;
    logic         inj_en;
    logic [7:0]   inj_pos;
    logic         out_ready;
    logic [255:0] codes  [4];
    logic         injs   [4];
    logic         vals   [4];
    logic         rdys   [4];
    logic [15:0]  counts [4];
    logic         acc;
    sb_t          sb [$];
    int           ncmp;
    int           nfail;
    logic [256:0] m;
    logic [255:0] hold;

    function automatic int tb_p(input int dw);
        int p;
        p = 1;
        for (int i = 0; i < 10; i++) begin
            if ((1 << p) < dw + p + 1) p++;
        end
        return p;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int CW = DWS[g] + tb_p(DWS[g]) + SECS[g];
        localparam int PW = $clog2(CW);
        hamming_secded_enc_if #(.DATA_W(DWS[g]), .SECDED(SECS[g])) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.in_data   = in_data[DWS[g]-1:0];
        assign bus.inj_en    = inj_en;
        assign bus.inj_pos   = inj_pos[PW-1:0];
        assign bus.out_ready = out_ready;
        assign codes[g] = 256'(bus.out_code);
        assign injs[g]  = bus.out_injected;
        assign vals[g]  = bus.out_valid;
        assign rdys[g]  = bus.in_ready;
        hamming_secded_enc #(
            .DATA_W (DWS[g]),
            .SECDED (SECS[g]),
            .INJ_EN (1)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (bus),
            .enc_count (counts[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: parity bits are the bits of the XOR of data-bit positions.
    function automatic logic [256:0] model(input int dw, input int sec, input logic [255:0] d,
                                           input logic inj, input logic [7:0] pos);
        int p, n, cw, pw, di, s, pe;
        logic [255:0] c;
        p  = tb_p(dw);
        n  = dw + p;
        cw = n + sec;
        c  = '0;
        di = 0;
        s  = 0;
        for (int k = 3; k <= n; k++) begin
            if ((k & (k - 1)) != 0) begin
                c[k-1] = d[di];
                if (d[di]) s = s ^ k;
                di++;
            end
        end
        for (int j = 0; j < p; j++) c[(1 << j) - 1] = s[j];
        if (sec != 0) c[n] = ^c;
        pw = $clog2(cw);
        pe = int'(pos) % (1 << pw);
        if (inj && pe < cw) begin
            c[pe] = ~c[pe];
            return {1'b1, c};
        end
        return {1'b0, c};
    endfunction

    function automatic int syndrome(input logic [255:0] c, input int n);
        int s;
        s = 0;
        for (int k = 1; k <= n; k++) begin
            if (c[k-1]) s = s ^ k;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        sb_t e;
        logic [256:0] r;
        int n, pw, pe, ex;
        chk("sb_nonempty", 257'(sb.size() > 0), 257'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int g = 0; g < 4; g++) begin
                r = model(DWS[g], SECS[g], e.data, e.inj, e.pos);
                chk($sformatf("code_w%0d", DWS[g]), 257'(codes[g]), 257'(r[255:0]));
                chk($sformatf("inj_w%0d", DWS[g]), 257'(injs[g]), 257'(r[256]));
                chk($sformatf("lockstep_w%0d", DWS[g]), 257'(vals[g]), 257'(1));
                if (r[256]) begin
                    n  = DWS[g] + tb_p(DWS[g]);
                    pw = $clog2(n + SECS[g]);
                    pe = int'(e.pos) % (1 << pw);
                    ex = (pe < n) ? pe + 1 : 0;
                    chk($sformatf("syndrome_w%0d", DWS[g]), 257'(syndrome(codes[g], n)), 257'(ex));
                end
            end
        end
    endtask

    // Record the transfers about to happen at the next edge, then advance.
    task automatic tick();
        logic ix, ox;
        ix = in_valid && rdys[1] && !rst;
        ox = vals[1] && out_ready && !rst;
        if (ox) check_out();
        if (ix) sb.push_back('{in_data, inj_en, inj_pos});
        acc = ix;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!in_valid && sb.size() == 0) break;
            tick();
            if (acc) in_valid = 1'b0;
        end
        chk("drain_sb_empty", 257'(sb.size()), 257'(0));
        chk("drain_input_taken", 257'(in_valid), 257'(0));
    endtask

    initial begin
        ncmp = 0; nfail = 0; acc = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; inj_en = 1'b0; inj_pos = 8'd0; out_ready = 1'b1;
        in_valid = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", 257'(rdys[1]), 257'(0));
        chk("rst_out_valid", 257'(vals[1]), 257'(0));
        chk("rst_count", 257'(counts[1]), 257'(0));
        in_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 10 && !rdys[1]; i++) tick();
        chk("ready_after_rst", 257'(rdys[1]), 257'(1));

        // Known vectors, one word per cycle.
        in_valid = 1'b1; in_data = 256'h1;
        tick();
        chk("latency_valid", 257'(vals[1]), 257'(1));
        chk("vec_one", 257'(codes[1]), 257'(39'h40_0000_0007));
        in_data = 256'h0;
        tick();
        chk("vec_zero", 257'(codes[1]), 257'(0));
        in_data = 256'hFFFF_FFFF;
        tick();
        chk("vec_ones", 257'(codes[1]), 257'(39'h3F_7FFF_FFF4));
        in_data = 256'h0; inj_en = 1'b1; inj_pos = 8'd5;
        tick();
        chk("inj5_code", 257'(codes[1]), 257'(39'h20));
        chk("inj5_flag", 257'(injs[1]), 257'(1));
        inj_pos = 8'd39;
        tick();
        chk("inj39_code", 257'(codes[1]), 257'(0));
        chk("inj39_flag", 257'(injs[1]), 257'(0));
        in_valid = 1'b0; inj_en = 1'b0;
        tick();
        chk("stream_drained", 257'(vals[1]), 257'(0));
        chk("count_5", 257'(counts[1]), 257'(5));

        // Reset while FULL.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 256'hDEAD_BEEF;
        tick();
        in_data = 256'hCAFE_F00D;
        tick();
        chk("full_in_ready", 257'(rdys[1]), 257'(0));
        rst = 1'b1;
        tick();
        sb.delete();
        chk("midrst_out_valid", 257'(vals[1]), 257'(0));
        chk("midrst_in_ready", 257'(rdys[1]), 257'(0));
        chk("midrst_count", 257'(counts[1]), 257'(0));
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            tick();
            chk("no_stale", 257'(vals[1]), 257'(0));
        end

        // Backpressure: three words against a stalled consumer.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 256'h1234_5678;
        tick();
        chk("bp_ready_one", 257'(rdys[1]), 257'(1));
        m = model(32, 1, 256'h1234_5678, 1'b0, 8'd0);
        hold = m[255:0];
        chk("bp_first", 257'(codes[1]), 257'(hold));
        in_data = 256'h9ABC_DEF0;
        tick();
        chk("bp_ready_low", 257'(rdys[1]), 257'(0));
        in_data = 256'h0F0F_0F0F;
        repeat (2) begin
            tick();
            chk("bp_stall_code", 257'(codes[1]), 257'(hold));
            chk("bp_stall_ready", 257'(rdys[1]), 257'(0));
        end
        out_ready = 1'b1;
        drain(20);
        chk("bp_count_3", 257'(counts[1]), 257'(3));

        // Random traffic with random injection and backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            for (int w = 0; w < 8; w++) in_data[w*32 +: 32] = $urandom();
            inj_en    = ($urandom_range(0, 3) == 0);
            inj_pos   = 8'($urandom_range(0, 140));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; inj_en = 1'b0; out_ready = 1'b1;
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/hamming_secded_enc.md
# hamming_secded_enc

Parametrised, pipelined Hamming SECDED encoder with valid/ready streaming handshake. Accepts one DATA_W-bit word per cycle and emits the single-error-correcting codeword, optionally extended with an overall-parity bit for double-error detection. Includes an optional single-bit fault-injection path for exercising downstream decoders. Sits between the data producer and the storage/link path, replacing the fixed 32-bit combinational encoder.

## Interface
- DATA_W, 32: data word width, 4..247.
- SECDED, 1: 1 appends the overall-parity bit at the codeword MSB; 0 gives plain SEC.
- INJ_EN, 1: 1 includes the fault-injection logic; 0 ties it off and ignores inj_* ports.
- Derived P: smallest integer with 2^P >= DATA_W+P+1. P = 6 for 32.
- Derived CW_W: DATA_W+P+SECDED. CW_W = 39 for the defaults.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  encoder can accept.
- in_data  in  DATA_W  data word.
- inj_en  in  1  flip one codeword bit of the word accepted this cycle.
- inj_pos  in  $clog2(CW_W)  bit index to flip. Index >= CW_W means no flip.
- out_valid  out  1  codeword present.
- out_ready  in  1  consumer accepts.
- out_code  out  CW_W  codeword.
- out_injected  out  1  the codeword carries an injected flip.
- enc_count  out  16  accepted-word count, saturating at 16'hFFFF.

## Operation
- Codeword layout:
  - Position k = 1..DATA_W+P maps to out_code[k-1].
  - Parity bit j sits at position 2^j.
  - Data bits fill the remaining positions in ascending order, with in_data[0] at position 3.
- Parity bit j is the XOR of all non-parity positions whose index has bit j set (even parity).
- When SECDED=1, out_code[CW_W-1] is the XOR of out_code[CW_W-2:0] before injection.
- Injection:
  - Applies only when INJ_EN=1, inj_en=1, the input transfer occurs, and inj_pos < CW_W.
  - The flip is applied after all parity is computed.
  - out_injected travels with the word.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- enc_count increments on each input transfer and holds at 16'hFFFF.
- Buffering uses a two-entry skid: a main output register plus a skid register.
  - in_ready is registered and equals "skid empty".
  - If out_ready is low while a word is presented, the incoming word parks in the skid.
  - The skid drains into main on the next output transfer.
- States: EMPTY (neither holds data), ONE (main only), FULL (main+skid).
  - EMPTY -> ONE on an input transfer.
  - ONE -> ONE on a simultaneous input and output transfer.
  - ONE -> EMPTY on an output transfer with no input.
  - ONE -> FULL on an input transfer with no output transfer.
  - FULL -> ONE on an output transfer. No input is accepted in FULL.
- Words are never dropped, duplicated or reordered.
- Data and injection flags in the output path are not reset. Only the valid/state bits and the counter are.

## Timing
- Latency: a word accepted in cycle t appears on out_code in cycle t+1 when EMPTY, or ONE with out_ready high.
- Throughput: one word per cycle under continuous out_ready.
- While rst is high:
  - in_ready=0, out_valid=0, enc_count=0, state=EMPTY. All in_valid is ignored.
  - First acceptance is possible in the cycle after rst deasserts.
- Reset mid-stream discards the main and skid contents in the same edge. No partial output follows reset.
- out_code and out_injected are stable while out_valid && !out_ready. A stalled output must not change.
- in_ready falls in the cycle after the skid fills. It rises in the cycle after the skid drains.

## Structure
- The shared package hamming_pkg holds:
  - function hamming_p(DATA_W) returning P.
  - function is_pow2(int).
  - localparam-ready cw_width(DATA_W, SECDED).
  - the position-to-data-index mapping function, so the future decoder reuses the identical layout.
- Sub-module hamming_skid: a generic two-entry valid/ready skid buffer, parametrised on payload width (CW_W+1).
- Parity generation and injection stay combinational in the top, feeding the skid input.

## Test plan
- DATA_W=32, SECDED=1: in_data=32'h0000_0001 -> out_code=39'h40_0000_0007 one cycle later. in_data=0 -> out_code=0.
- in_data=32'hFFFF_FFFF -> out_code=39'h3F_7FFF_FFF4, i.e. parity at positions 8 and 16 only, overall parity 0.
- Injection:
  - in_data=0 with inj_en=1, inj_pos=5 -> out_code=39'h20, out_injected=1.
  - inj_pos=39 -> out_code=0, out_injected=0.
- Backpressure:
  - Hold out_ready=0 and stream 3 words.
  - Expect in_ready=0 after 2 acceptances and out_code stable.
  - Release out_ready -> all 3 words are received in order, enc_count=3.
- Reset mid-stream:
  - Assert rst with FULL state.
  - Expect out_valid=0, in_ready=0, enc_count=0 next cycle.
  - No stale word is emitted after release.
- Random regression with DATA_W in {8,32,64,120}, random valid/ready:
  - A scoreboard model matches every codeword.
  - Any single-bit flip gives a nonzero syndrome equal to the flipped position.
